mem_access_ctrl: RTL and testbench

//  Load/store sequencer between the MEM pipeline stage and the SRAM-like data bus.

---
 rtl/mem_access_ctrl_pkg.sv | 34 +++
 rtl/mem_access_ctrl_ram_ext.sv | 27 ++
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, load-extension ops,
// sequencer states and the alignment rule.
package mem_access_ctrl_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    localparam logic [2:0] RAM_EXT_W  = 3'd0;
    localparam logic [2:0] RAM_EXT_B  = 3'd1;
    localparam logic [2:0] RAM_EXT_BU = 3'd2;
    localparam logic [2:0] RAM_EXT_H  = 3'd3;
    localparam logic [2:0] RAM_EXT_HU = 3'd4;

    typedef enum logic [2:0] {
        MAC_IDLE  = 3'd0,
        MAC_REQ   = 3'd1,
        MAC_WAIT  = 3'd2,
        MAC_DONE  = 3'd3,
        MAC_ABORT = 3'd4
    } mac_state_e;

    // Sizes outside B/H are checked as words.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = off[0];
            default:    bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_ram_ext.sv
// Load extension: selects the addressed byte/half of a bus word and sign- or
// zero-extends it to 32 bits.
module mem_access_ctrl_ram_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] din_i,
    input  logic [1:0]  byte_offset_i,
    input  logic [2:0]  ext_op_i,
    output logic [31:0] dout_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = din_i[{byte_offset_i, 3'b000} +: 8];
        half_sel = byte_offset_i[1] ? din_i[31:16] : din_i[15:0];
        case (ext_op_i)
            RAM_EXT_B:  dout_o = {{24{byte_sel[7]}}, byte_sel};
            RAM_EXT_BU: dout_o = {24'd0, byte_sel};
            RAM_EXT_H:  dout_o = {{16{half_sel[15]}}, half_sel};
            RAM_EXT_HU: dout_o = {16'd0, half_sel};
            default:    dout_o = din_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and an SRAM-like req/addr_ok/data_ok bus:
// one access in flight, alignment trap, store lane steering, load extension.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [1:0]        in_size,
    input  logic [2:0]        in_ext_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_ale,
    output logic [ADDR_W-1:0] out_badv,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    mac_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        ext_q, ext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ale_q, ale_d;
    logic [ADDR_W-1:0] badv_q, badv_d;

    logic [31:0]       ext_dout;
    logic [3:0]        strb;
    logic [31:0]       lane_wdata;
    logic              in_req;

    mem_access_ctrl_ram_ext u_ram_ext (
        .din_i         (data_rdata),
        .byte_offset_i (addr_q[1:0]),
        .ext_op_i      (ext_q),
        .dout_o        (ext_dout)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= MAC_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            ext_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ale_q   <= 1'b0;
            badv_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            ext_q   <= ext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ale_q   <= ale_d;
            badv_q  <= badv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        ext_d   = ext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ale_d   = ale_q;
        badv_d  = badv_q;
        case (state_q)
            MAC_IDLE: begin
                // A flush in the accept cycle kills the offered access as well.
                if (in_valid && !flush) begin
                    we_d    = in_we;
                    size_d  = in_size;
                    ext_d   = in_ext_op;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    rdata_d = 32'd0;
                    if (misaligned(in_size, in_addr[1:0])) begin
                        ale_d   = 1'b1;
                        badv_d  = in_addr;
                        state_d = MAC_DONE;
                    end else begin
                        ale_d   = 1'b0;
                        badv_d  = '0;
                        state_d = MAC_REQ;
                    end
                end
            end
            MAC_REQ: begin
                // Address already taken by the bus: its response must still be drained.
                if (flush) state_d = data_addr_ok ? MAC_ABORT : MAC_IDLE;
                else if (data_addr_ok) state_d = MAC_WAIT;
            end
            MAC_WAIT: begin
                if (flush) begin
                    state_d = MAC_ABORT;
                end else if (data_data_ok) begin
                    state_d = MAC_DONE;
                    if (!we_q) rdata_d = ext_dout;
                end
            end
            MAC_ABORT: begin
                if (data_data_ok) state_d = MAC_IDLE;
            end
            MAC_DONE: begin
                if (flush || out_ready) state_d = MAC_IDLE;
            end
            default: state_d = MAC_IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            MEM_SIZE_B: begin
                strb       = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            MEM_SIZE_H: begin
                strb       = 4'b0011 << addr_q[1:0];
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                strb       = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    assign in_req     = (state_q == MAC_REQ);
    assign in_ready   = (state_q == MAC_IDLE);
    assign out_valid  = (state_q == MAC_DONE);
    assign out_rdata  = rdata_q;
    assign out_ale    = ale_q;
    assign out_badv   = badv_q;
    assign data_req   = in_req;
    assign data_wr    = in_req & we_q;
    assign data_size  = in_req ? size_q : 2'd0;
    assign data_addr  = in_req ? addr_q : '0;
    assign data_wstrb = (in_req && we_q) ? strb : 4'd0;
    assign data_wdata = (in_req && we_q) ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of single accesses plus
// hand-written stall, flush and reset sequences.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst, flush, in_valid, in_ready, in_we;
    logic [1:0]  in_size;
    logic [2:0]  in_ext_op;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_ale;
    logic [31:0] out_rdata, out_badv;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 cpu_clk = ~cpu_clk;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_size(in_size),
        .in_ext_op(in_ext_op), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_ale(out_ale), .out_badv(out_badv),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [2:0]  ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ale;
        logic [3:0]  wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic offer(input logic we, input logic [1:0] size, input logic [2:0] ext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        in_valid  = 1'b1;
        in_we     = we;
        in_size   = size;
        in_ext_op = ext;
        in_addr   = addr;
        in_wdata  = wdata;
        tick();
        in_valid  = 1'b0;
        in_wdata  = 32'h0BAD_F00D;
        in_addr   = 32'hFFFF_FFFC;
    endtask

    task automatic idle_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_outs"}, {27'd0, out_valid, out_ale, data_req, data_wr, |data_wstrb}, 32'd0);
        chk({tag, "_rdata"}, out_rdata, 32'd0);
        chk({tag, "_badv"}, out_badv, 32'd0);
        chk({tag, "_bus"}, data_addr | data_wdata | {30'd0, data_size}, 32'd0);
    endtask

    initial begin
        //            we    size        ext         addr          wdata         rdata         ale   wstrb    exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, MEM_SIZE_B, RAM_EXT_B,  32'h0000_1003, 32'hFFFF_FFFF, 32'h80FF_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, MEM_SIZE_H, RAM_EXT_B,  32'h0000_2002, 32'h0000_ABCD, 32'hDEAD_BEEF, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000};
        vecs[2]  = '{1'b0, MEM_SIZE_W, RAM_EXT_W,  32'h0000_3002, 32'h0000_0000, 32'h1111_1111, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, MEM_SIZE_B, RAM_EXT_BU, 32'h0000_1001, 32'h1234_0000, 32'h1234_5678, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0056};
        vecs[4]  = '{1'b0, MEM_SIZE_H, RAM_EXT_H,  32'h0000_1002, 32'h0000_0000, 32'h8001_7FFF, 1'b0, 4'b0000, 32'h0000_0000, 32'hFFFF_8001};
        vecs[5]  = '{1'b0, MEM_SIZE_H, RAM_EXT_HU, 32'h0000_1000, 32'h0000_0000, 32'h1234_9ABC, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_9ABC};
        vecs[6]  = '{1'b0, MEM_SIZE_W, RAM_EXT_W,  32'h0000_1004, 32'h0000_0000, 32'hCAFE_BABE, 1'b0, 4'b0000, 32'h0000_0000, 32'hCAFE_BABE};
        vecs[7]  = '{1'b1, MEM_SIZE_B, RAM_EXT_W,  32'h0000_4001, 32'h0000_00A5, 32'h5555_5555, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000};
        vecs[8]  = '{1'b1, MEM_SIZE_W, RAM_EXT_W,  32'h0000_4008, 32'h1122_3344, 32'h5555_5555, 1'b0, 4'b1111, 32'h1122_3344, 32'h0000_0000};
        vecs[9]  = '{1'b1, MEM_SIZE_H, RAM_EXT_W,  32'h0000_4001, 32'h0000_1234, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b0, MEM_SIZE_H, RAM_EXT_H,  32'h0000_5003, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1'b1, MEM_SIZE_B, RAM_EXT_W,  32'h0000_4003, 32'hFFFF_FF7E, 32'h5555_5555, 1'b0, 4'b1000, 32'h7E7E_7E7E, 32'h0000_0000};

        cpu_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_size = 2'd0;
        in_ext_op = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; out_ready = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        tick(); tick();
        cpu_rst = 1'b0;
        idle_all_zero("reset");

        for (int i = 0; i < NVEC; i++) begin
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            offer(vecs[i].we, vecs[i].size, vecs[i].ext, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].ale) begin
                chk($sformatf("v%0d_ale_valid", i), {30'd0, out_valid, data_req}, 32'd2);
                chk($sformatf("v%0d_ale", i), {31'd0, out_ale}, 32'd1);
                chk($sformatf("v%0d_badv", i), out_badv, vecs[i].addr);
                chk($sformatf("v%0d_rdata", i), out_rdata, 32'd0);
            end else begin
                chk($sformatf("v%0d_req", i), {29'd0, data_req, data_wr, out_valid}, {29'd0, 1'b1, vecs[i].we, 1'b0});
                chk($sformatf("v%0d_addr", i), data_addr, vecs[i].addr);
                chk($sformatf("v%0d_size", i), {30'd0, data_size}, {30'd0, vecs[i].size});
                chk($sformatf("v%0d_wstrb", i), {28'd0, data_wstrb}, {28'd0, vecs[i].wstrb});
                chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].exp_wdata);
                data_addr_ok = 1'b1;
                tick();
                data_addr_ok = 1'b0;
                chk($sformatf("v%0d_wait", i), {30'd0, data_req, out_valid}, 32'd0);
                data_data_ok = 1'b1;
                data_rdata   = vecs[i].rdata;
                tick();
                data_data_ok = 1'b0;
                data_rdata   = 32'h0;
                chk($sformatf("v%0d_done", i), {30'd0, out_valid, out_ale}, 32'd2);
                chk($sformatf("v%0d_rdata", i), out_rdata, vecs[i].exp_rdata);
            end
            $display("vec %0d we=%0b size=%0d addr=%h rdata=%h ale=%0b bad=%0d",
                     i, vecs[i].we, vecs[i].size, vecs[i].addr, out_rdata, out_ale, bad);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_release", i), {30'd0, in_ready, out_valid}, 32'd2);
        end

        // addr_ok stall then consumer stall on a load
        offer(1'b0, MEM_SIZE_W, RAM_EXT_W, 32'h0000_6000, 32'h0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_req", c), {31'd0, data_req}, 32'd1);
            chk($sformatf("stall%0d_addr", c), data_addr, 32'h0000_6000);
            chk($sformatf("stall%0d_size", c), {26'd0, data_size, data_wstrb}, {26'd0, MEM_SIZE_W, 4'b0000});
            tick();
        end
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h0102_0304; tick(); data_data_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_rdata = 32'hFFFF_0000 + c;
            chk($sformatf("hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d_rdata", c), out_rdata, 32'h0102_0304);
            tick();
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("seq stall: bad=%0d", bad);

        // flush in REQ
        offer(1'b0, MEM_SIZE_B, RAM_EXT_B, 32'h0000_7001, 32'h0);
        chk("flreq_req", {31'd0, data_req}, 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flreq_after", {30'd0, in_ready, data_req}, 32'd2);
        tick();
        chk("flreq_quiet", {30'd0, data_req, out_valid}, 32'd0);
        $display("seq flush_req: bad=%0d", bad);

        // flush in WAIT, late response discarded
        offer(1'b0, MEM_SIZE_W, RAM_EXT_W, 32'h0000_7004, 32'h0);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        chk("abort_busy", {29'd0, in_ready, out_valid, data_req}, 32'd0);
        tick();
        chk("abort_hold", {30'd0, in_ready, out_valid}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; tick(); data_data_ok = 1'b0;
        chk("abort_idle", {30'd0, in_ready, out_valid}, 32'd2);
        tick();
        chk("abort_novalid", {31'd0, out_valid}, 32'd0);
        chk("abort_rdata", out_rdata, 32'd0);
        $display("seq flush_wait: bad=%0d", bad);

        // reset in WAIT, then a stray data_ok in IDLE
        offer(1'b0, MEM_SIZE_W, RAM_EXT_W, 32'h0000_8000, 32'h0);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        chk("rstw_wait", {31'd0, in_ready}, 32'd0);
        cpu_rst = 1'b1; tick(); cpu_rst = 1'b0;
        idle_all_zero("rstw");
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678; tick(); data_data_ok = 1'b0;
        idle_all_zero("stray");
        $display("seq reset_wait: bad=%0d", bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
